// File: rtl/hier_child_sequencer.sv
// hier_child_sequencer: dispatches go pulses to child nodes in parallel or in sequence,
// collects their done pulses under a per-phase timeout, and reports done/error upward.
module hier_child_sequencer #(
  parameter int NUM_CHILDREN = 10,
  parameter int TIMEOUT_W = 16,
  parameter int IDX_W = $clog2(NUM_CHILDREN > 1 ? NUM_CHILDREN : 2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    seq_mode_i,
  input  logic [TIMEOUT_W-1:0]    timeout_i,
  output logic [NUM_CHILDREN-1:0] child_go_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [IDX_W-1:0]        err_child_o
);
  typedef enum logic [2:0] {IDLE, GO_PAR, WAIT_PAR, GO_SEQ, WAIT_SEQ, FIN} state_t;
  state_t state, state_nxt;
  logic [NUM_CHILDREN-1:0] pending, pend_nxt;
  logic [IDX_W-1:0] idx, low;
  logic [TIMEOUT_W-1:0] timer;
  logic seq_hit, last, tmo;
  always_comb begin
    pend_nxt = pending & ~child_done_i;
    seq_hit = child_done_i[idx];
    last = idx == IDX_W'(NUM_CHILDREN - 1);
    tmo = timeout_i != '0 && timer == timeout_i - TIMEOUT_W'(1);
    low = '0;
    for (int k = NUM_CHILDREN - 1; k >= 0; k--)
      if (pend_nxt[k]) low = IDX_W'(k);
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = start_i ? (seq_mode_i ? GO_SEQ : GO_PAR) : IDLE;
      GO_PAR:   state_nxt = WAIT_PAR;
      WAIT_PAR: state_nxt = (pend_nxt == '0 || tmo) ? FIN : WAIT_PAR;
      GO_SEQ:   state_nxt = WAIT_SEQ;
      WAIT_SEQ: state_nxt = seq_hit ? (last ? FIN : GO_SEQ) : (tmo ? FIN : WAIT_SEQ);
      default:  state_nxt = IDLE;
    endcase
  end
  always_comb begin
    child_go_o = state == GO_PAR ? '1 : state == GO_SEQ ? NUM_CHILDREN'(1) << idx : '0;
    busy_o = state != IDLE && state != FIN;
    done_o = state == FIN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      idx <= '0;
      timer <= '0;
      err_o <= 1'b0;
      err_child_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start_i) begin
          err_o <= 1'b0;
          err_child_o <= '0;
          timer <= '0;
        end
        GO_PAR: begin
          pending <= ~child_done_i;
          timer <= '0;
        end
        GO_SEQ: timer <= '0;
        WAIT_PAR: begin
          pending <= pend_nxt;
          timer <= timer == '1 ? timer : timer + TIMEOUT_W'(1);
          if (pend_nxt != '0 && tmo) begin
            err_o <= 1'b1;
            err_child_o <= low;
          end
        end
        WAIT_SEQ: begin
          timer <= timer == '1 ? timer : timer + TIMEOUT_W'(1);
          if (seq_hit && !last) idx <= idx + IDX_W'(1);
          if (!seq_hit && tmo) begin
            err_o <= 1'b1;
            err_child_o <= idx;
          end
        end
        default: idx <= '0;
      endcase
    end
  end
endmodule
